// File: rtl/packed_slice_pkg.sv
// Shared types and the element/bit-to-flat-index rule for the packed slice block.
package packed_slice_pkg;

   typedef enum logic [1:0] {OP_RD = 2'd0, OP_WR = 2'd1, OP_CLR = 2'd2, OP_SET = 2'd3} op_e;

   typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_e;

   // Ascending layout puts element 0 / bit 0 at the top of the flat vector.
   function automatic int flat_idx(input int e, input int b, input bit little,
                                   input int wa, input int wb);
      return little ? (wa - 1 - e) * wb + (wb - 1 - b) : e * wb + b;
   endfunction

endpackage

// File: rtl/packed_slice_map.sv
// Combinational range decode: write mask, range error, scatter of right-aligned
// data onto flat bits and gather of flat bits into a right-aligned slice.
module packed_slice_map
   import packed_slice_pkg::*;
#(
   parameter int WA     = 8,
   parameter int WB     = 8,
   parameter bit LITTLE = 1'b0,
   localparam int AW    = (WA > 1) ? $clog2(WA) : 1,
   localparam int BW    = (WB > 1) ? $clog2(WB) : 1,
   localparam int N     = WA * WB,
   localparam int NW    = (N > 1) ? $clog2(N) : 1
) (
   input  logic [AW-1:0] elo,
   input  logic [AW-1:0] ehi,
   input  logic [BW-1:0] blo,
   input  logic [BW-1:0] bhi,
   input  logic [N-1:0]  wdata,
   input  logic [N-1:0]  arr,
   output logic [N-1:0]  mask,
   output logic          err,
   output logic [N-1:0]  scat,
   output logic [N-1:0]  gath
);

   int elo_i, ehi_i, blo_i, bhi_i, w, f, p;

   always_comb begin
      elo_i = int'(elo);
      ehi_i = int'(ehi);
      blo_i = int'(blo);
      bhi_i = int'(bhi);
      err   = (elo_i > ehi_i) || (ehi_i >= WA) || (blo_i > bhi_i) || (bhi_i >= WB);
      w     = bhi_i - blo_i + 1;
      mask  = '0;
      scat  = '0;
      gath  = '0;
      f     = 0;
      p     = 0;
      for (int e = 0; e < WA; e++) begin
         for (int b = 0; b < WB; b++) begin
            if (!err && e >= elo_i && e <= ehi_i && b >= blo_i && b <= bhi_i) begin
               f = flat_idx(e, b, LITTLE, WA, WB);
               // Slice MSB is the leftmost declared element/bit of the range.
               p = LITTLE ? (ehi_i - e) * w + (bhi_i - b) : (e - elo_i) * w + (b - blo_i);
               mask[NW'(f)] = 1'b1;
               scat[NW'(f)] = wdata[NW'(p)];
               gath[NW'(p)] = arr[NW'(f)];
            end
         end
      end
   end

endmodule

// File: rtl/packed_slice_rw.sv
// Packed 2-D array store serving a valid/ready RD/WR/CLR/SET slice command
// stream with one response per command and a saturating reject counter.
module packed_slice_rw
   import packed_slice_pkg::*;
#(
   parameter int WA     = 8,
   parameter int WB     = 8,
   parameter bit LITTLE = 1'b0,
   localparam int AW    = (WA > 1) ? $clog2(WA) : 1,
   localparam int BW    = (WB > 1) ? $clog2(WB) : 1,
   localparam int N     = WA * WB
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [1:0]    cmd_op,
   input  logic [AW-1:0] cmd_elo,
   input  logic [AW-1:0] cmd_ehi,
   input  logic [BW-1:0] cmd_blo,
   input  logic [BW-1:0] cmd_bhi,
   input  logic [N-1:0]  cmd_wdata,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [N-1:0]  rsp_data,
   output logic          rsp_err,
   output logic [N-1:0]  array_q,
   output logic [7:0]    err_cnt
);

   state_e        state, state_nxt;
   op_e           op_q;
   logic [AW-1:0] elo_q, ehi_q;
   logic [BW-1:0] blo_q, bhi_q;
   logic [N-1:0]  wdata_q;
   logic [N-1:0]  mask, scat, gath, fill;
   logic          err;

   packed_slice_map #(.WA(WA), .WB(WB), .LITTLE(LITTLE)) u_map (
      .elo   (elo_q),
      .ehi   (ehi_q),
      .blo   (blo_q),
      .bhi   (bhi_q),
      .wdata (wdata_q),
      .arr   (array_q),
      .mask  (mask),
      .err   (err),
      .scat  (scat),
      .gath  (gath)
   );

   assign cmd_ready = rst_n && (state == IDLE);
   assign rsp_valid = (state == RESP);
   assign fill      = (op_q == OP_WR) ? scat : (op_q == OP_SET) ? '1 : '0;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (cmd_valid && cmd_ready) state_nxt = EXEC;
         EXEC:    state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         array_q  <= '0;
         err_cnt  <= '0;
         rsp_data <= '0;
         rsp_err  <= 1'b0;
         op_q     <= OP_RD;
         elo_q    <= '0;
         ehi_q    <= '0;
         blo_q    <= '0;
         bhi_q    <= '0;
         wdata_q  <= '0;
      end else begin
         if (state == IDLE && cmd_valid) begin
            op_q    <= op_e'(cmd_op);
            elo_q   <= cmd_elo;
            ehi_q   <= cmd_ehi;
            blo_q   <= cmd_blo;
            bhi_q   <= cmd_bhi;
            wdata_q <= cmd_wdata;
         end
         if (state == EXEC) begin
            if (err) begin
               rsp_err  <= 1'b1;
               rsp_data <= '0;
               if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end else begin
               rsp_err  <= 1'b0;
               rsp_data <= (op_q == OP_RD) ? gath : '0;
               if (op_q != OP_RD) array_q <= (array_q & ~mask) | (fill & mask);
            end
         end
      end
   end

endmodule

// File: tb/tb_packed_slice_rw.sv
// Drives descending and ascending instances in lockstep and checks both
// against a per-element bit model of the array.
module tb_packed_slice_rw;
   localparam int WA = 8, WB = 8, AW = 3, BW = 3, N = WA * WB;

   logic          clk = 1'b0;
   logic          rst_n, cmd_valid, rsp_ready;
   logic [1:0]    cmd_op;
   logic [AW-1:0] cmd_elo, cmd_ehi;
   logic [BW-1:0] cmd_blo, cmd_bhi;
   logic [N-1:0]  cmd_wdata;
   logic          cmd_ready [2];
   logic          rsp_valid [2];
   logic          rsp_err   [2];
   logic [N-1:0]  rsp_data  [2];
   logic [N-1:0]  aq        [2];
   logic [7:0]    ecnt      [2];

   int ncmp = 0, nfail = 0;
   bit m [2][WA][WB];
   int err_m = 0;

   always #5 clk = ~clk;

   packed_slice_rw #(.WA(WA), .WB(WB), .LITTLE(1'b0)) u_dsc (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[0]),
      .cmd_op(cmd_op), .cmd_elo(cmd_elo), .cmd_ehi(cmd_ehi), .cmd_blo(cmd_blo),
      .cmd_bhi(cmd_bhi), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid[0]),
      .rsp_ready(rsp_ready), .rsp_data(rsp_data[0]), .rsp_err(rsp_err[0]),
      .array_q(aq[0]), .err_cnt(ecnt[0]));

   packed_slice_rw #(.WA(WA), .WB(WB), .LITTLE(1'b1)) u_asc (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[1]),
      .cmd_op(cmd_op), .cmd_elo(cmd_elo), .cmd_ehi(cmd_ehi), .cmd_blo(cmd_blo),
      .cmd_bhi(cmd_bhi), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid[1]),
      .rsp_ready(rsp_ready), .rsp_data(rsp_data[1]), .rsp_err(rsp_err[1]),
      .array_q(aq[1]), .err_cnt(ecnt[1]));

   task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [N-1:0] model_flat(input int l);
      logic [N-1:0] v = '0;
      for (int e = 0; e < WA; e++)
         for (int b = 0; b < WB; b++)
            if (l == 0) v[e*WB + b] = m[l][e][b];
            else        v[(WA-1-e)*WB + (WB-1-b)] = m[l][e][b];
      return v;
   endfunction

   // Walk the range in declaration order (leftmost first) for each layout.
   task automatic model_cmd(input int op, input int el, input int eh, input int bl, input int bh,
                            input logic [N-1:0] wd, output logic [1:0][N-1:0] rd, output bit rej);
      int k;
      rd  = '0;
      rej = (el > eh) || (eh >= WA) || (bl > bh) || (bh >= WB);
      if (rej) begin
         if (err_m < 255) err_m++;
         return;
      end
      for (int l = 0; l < 2; l++) begin
         k = (eh - el + 1) * (bh - bl + 1) - 1;
         for (int ei = 0; ei <= eh - el; ei++) begin
            for (int bi = 0; bi <= bh - bl; bi++) begin
               int e, b;
               e = (l == 1) ? el + ei : eh - ei;
               b = (l == 1) ? bl + bi : bh - bi;
               case (op)
                  0: rd[l][k] = m[l][e][b];
                  1: m[l][e][b] = wd[k];
                  2: m[l][e][b] = 1'b0;
                  default: m[l][e][b] = 1'b1;
               endcase
               k--;
            end
         end
      end
   endtask

   task automatic check_rsp(input string tag, input logic [1:0][N-1:0] rd, input bit rej);
      for (int l = 0; l < 2; l++) begin
         chk($sformatf("%s_l%0d_valid", tag, l), N'(rsp_valid[l]), N'(1));
         chk($sformatf("%s_l%0d_data", tag, l), rsp_data[l], rd[l]);
         chk($sformatf("%s_l%0d_err", tag, l), N'(rsp_err[l]), N'(rej));
         chk($sformatf("%s_l%0d_arr", tag, l), aq[l], model_flat(l));
         chk($sformatf("%s_l%0d_ecnt", tag, l), N'(ecnt[l]), N'(err_m));
      end
   endtask

   // Entered and left at a negedge with the DUTs idle.
   task automatic do_cmd(input string tag, input int op, input int el, input int eh,
                         input int bl, input int bh, input logic [N-1:0] wd, input bit hold);
      logic [1:0][N-1:0] rd;
      bit rej;
      for (int l = 0; l < 2; l++) chk($sformatf("%s_l%0d_rdy", tag, l), N'(cmd_ready[l]), N'(1));
      cmd_valid = 1'b1;
      cmd_op    = 2'(op);
      cmd_elo   = AW'(el);
      cmd_ehi   = AW'(eh);
      cmd_blo   = BW'(bl);
      cmd_bhi   = BW'(bh);
      cmd_wdata = wd;
      if (hold) rsp_ready = 1'b0;
      @(posedge clk);
      model_cmd(op, el, eh, bl, bh, wd, rd, rej);
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int l = 0; l < 2; l++) begin
         chk($sformatf("%s_l%0d_exec_vld", tag, l), N'(rsp_valid[l]), N'(0));
         chk($sformatf("%s_l%0d_exec_rdy", tag, l), N'(cmd_ready[l]), N'(0));
      end
      @(negedge clk);
      check_rsp(tag, rd, rej);
      if (hold) begin
         for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_rsp($sformatf("%s_hold%0d", tag, c), rd, rej);
            for (int l = 0; l < 2; l++)
               chk($sformatf("%s_hold_l%0d_rdy", tag, l), N'(cmd_ready[l]), N'(0));
         end
         rsp_ready = 1'b1;
      end
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b1; cmd_op = '0;
      cmd_elo = '0; cmd_ehi = '0; cmd_blo = '0; cmd_bhi = '0; cmd_wdata = '0;
      repeat (2) @(negedge clk);
      for (int l = 0; l < 2; l++) begin
         chk($sformatf("rst_l%0d_rdy", l), N'(cmd_ready[l]), N'(0));
         chk($sformatf("rst_l%0d_vld", l), N'(rsp_valid[l]), N'(0));
         chk($sformatf("rst_l%0d_data", l), rsp_data[l], '0);
         chk($sformatf("rst_l%0d_err", l), N'(rsp_err[l]), N'(0));
         chk($sformatf("rst_l%0d_arr", l), aq[l], '0);
         chk($sformatf("rst_l%0d_ecnt", l), N'(ecnt[l]), N'(0));
      end
      rst_n = 1'b1;
      @(negedge clk);

      do_cmd("t1_rd_all", 0, 0, 7, 0, 7, '0, 1'b0);
      do_cmd("t2_set", 3, 0, 3, 0, 7, '0, 1'b0);
      chk("t2_arr_dsc", aq[0], 64'h00000000_FFFFFFFF);
      chk("t2_arr_asc", aq[1], 64'hFFFFFFFF_00000000);
      do_cmd("t2_rd", 0, 0, 3, 0, 7, '0, 1'b0);
      do_cmd("t2_clr_all", 2, 0, 7, 0, 7, '0, 1'b0);
      do_cmd("t3_set", 3, 0, 0, 0, 3, '0, 1'b0);
      chk("t3_arr_dsc", aq[0], 64'h0F);
      chk("t3_arr_asc", aq[1], 64'hF000_0000_0000_0000);
      do_cmd("t3_clr", 2, 0, 0, 0, 3, '0, 1'b0);
      chk("t3_clr_dsc", aq[0], '0);
      chk("t3_clr_asc", aq[1], '0);
      do_cmd("t4_wr", 1, 7, 7, 4, 7, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0);
      chk("t4_arr_dsc", aq[0], 64'hA000_0000_0000_0000);
      chk("t4_arr_asc", aq[1], 64'h0A);
      do_cmd("t4_rd", 0, 7, 7, 0, 7, '0, 1'b0);
      do_cmd("t5_rej_e", 3, 5, 2, 0, 7, '0, 1'b0);
      chk("t5_ecnt1", N'(ecnt[0]), N'(1));
      do_cmd("t5_rej_b", 1, 0, 7, 6, 3, '1, 1'b0);
      chk("t5_ecnt2", N'(ecnt[1]), N'(2));

      for (int i = 0; i < 80; i++) begin
         int lo_e, hi_e, lo_b, hi_b;
         lo_e = $urandom_range(0, 7);
         hi_e = (($urandom % 4) == 0) ? $urandom_range(0, 7) : $urandom_range(lo_e, 7);
         lo_b = $urandom_range(0, 7);
         hi_b = (($urandom % 4) == 0) ? $urandom_range(0, 7) : $urandom_range(lo_b, 7);
         do_cmd($sformatf("rnd%0d", i), $urandom_range(0, 3), lo_e, hi_e, lo_b, hi_b,
                {$urandom, $urandom}, (i % 16) == 5);
      end

      for (int i = 0; i < 300; i++) do_cmd("t5_flood", $urandom_range(0, 3), 6, 1, 0, 7, '1, 1'b0);
      chk("t5_sat_dsc", N'(ecnt[0]), N'(255));
      chk("t5_sat_asc", N'(ecnt[1]), N'(255));

      do_cmd("t6_bp_set", 3, 2, 5, 1, 6, '0, 1'b0);
      do_cmd("t6_bp_rd", 0, 1, 6, 0, 7, '0, 1'b1);

      // Reset while a response is pending: it must vanish and the array clear.
      cmd_valid = 1'b1; cmd_op = 2'd0; cmd_elo = 3'd0; cmd_ehi = 3'd7;
      cmd_blo = 3'd0; cmd_bhi = 3'd7; rsp_ready = 1'b0;
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      for (int l = 0; l < 2; l++) chk($sformatf("t6_pend_l%0d_vld", l), N'(rsp_valid[l]), N'(1));
      rst_n = 1'b0;
      @(negedge clk);
      for (int l = 0; l < 2; l++) begin
         chk($sformatf("t6_rst_l%0d_vld", l), N'(rsp_valid[l]), N'(0));
         chk($sformatf("t6_rst_l%0d_arr", l), aq[l], '0);
         chk($sformatf("t6_rst_l%0d_ecnt", l), N'(ecnt[l]), N'(0));
      end
      for (int l = 0; l < 2; l++)
         for (int e = 0; e < WA; e++)
            for (int b = 0; b < WB; b++) m[l][e][b] = 1'b0;
      err_m = 0;
      rsp_ready = 1'b1;
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         for (int l = 0; l < 2; l++) chk($sformatf("t6_post_l%0d_vld", l), N'(rsp_valid[l]), N'(0));
      end
      do_cmd("t6_post_rd", 0, 0, 7, 0, 7, '0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
